vector_lsu: RTL and testbench
=============================

VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 Parameter DATA_W, default 16, width of one lane and of the RAM data word.
REQ-002 Parameter LANES, default 8, lanes per vector; legal range 2..16.
REQ-003 Parameter ADDR_W, default 16, RAM address width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk is the clock, reset the reset.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, request a vector transfer; sampled only in IDLE.
- is_store, in, 1, 1 = store vector to RAM, 0 = load; sampled with start.
- base_addr, in, ADDR_W, address of lane 0.
- stride, in, ADDR_W, unsigned address increment per lane.
- lane_mask, in, LANES, bit i enables lane i.
- store_vec, in, LANES*DATA_W, store data; lane i at bits [i*DATA_W +: DATA_W].
- busy, out, 1, transfer in progress; drives the pipeline stall.
- done, out, 1, one-cycle completion pulse.
- load_vec, out, LANES*DATA_W, loaded vector, same lane packing.
- mem_addr, out, ADDR_W, RAM address.
- mem_wdata, out, DATA_W, RAM write data.
- mem_wren, out, 1, RAM write enable.
- mem_rdata, in, DATA_W, RAM read data, valid one cycle after its address (registered RAM).

Function
REQ-006 The block SHALL implement the FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-007 In IDLE with start=1, it SHALL latch is_store, base_addr, stride, lane_mask and store_vec, then enter ISSUE; the held snapshot is used for the whole transfer.
REQ-008 The ISSUE state SHALL last exactly LANES cycles, one per lane i = 0..LANES-1, with mem_addr = base_addr + i*stride truncated to ADDR_W bits (wrap-around).
REQ-009 Store: in ISSUE cycle i, mem_wdata = lane i of the snapshot and mem_wren = lane_mask[i]; after the last lane the FSM SHALL go to DONE.
REQ-010 Load: mem_wren = 0 throughout; mem_rdata is captured into shadow lane i-1 during ISSUE cycle i; after the last lane the FSM SHALL go to DRAIN for one cycle to capture lane LANES-1, then go to DONE.
REQ-011 For a masked-off load lane (lane_mask[i]=0), the address SHALL still be issued and the shadow lane SHALL be written with zero.
REQ-012 load_vec SHALL update only on entry to DONE, atomically from the shadow buffer; a store SHALL leave load_vec unchanged.
REQ-013 DONE SHALL last one cycle with done=1, then return to IDLE; start is not accepted in DONE.
REQ-014 Latency from the start-sampling edge to done high SHALL be LANES+1 cycles for a store and LANES+2 cycles for a load (fixed and mask-independent).
REQ-015 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-016 start asserted while busy=1 SHALL be ignored; the request is not queued.
REQ-017 stride=0 SHALL be legal: every lane accesses base_addr (broadcast load, or last-enabled-lane-wins store).
REQ-018 In IDLE, mem_addr, mem_wdata and mem_wren SHALL all be 0.

Reset
REQ-019 With reset=1 at a clock edge: state goes to IDLE; busy, done, mem_wren, mem_addr and mem_wdata become 0; load_vec, the shadow buffer and the snapshot registers become 0.
REQ-020 Reset in the middle of a transfer SHALL abort it with no further RAM writes from the cycle after the reset edge, and done SHALL not pulse.
REQ-021 Reset SHALL take priority over start.

Structure
REQ-022 The shared package vec_pkg SHALL hold the DATA_W, LANES and ADDR_W defaults and the vlsu_state_t enum.
REQ-023 A sub-module vlsu_addr_gen (lane counter plus running address accumulator, addr += stride each cycle) SHALL generate the lane index and mem_addr; multipliers are not permitted.

Verification
REQ-024 The bench SHALL cover these directed scenarios (default parameters):
- Load with base=0x0010, stride=1, mask=0xFF, RAM[0x10..0x17]=0x1111..0x8888 -> done at cycle +10, load_vec lanes = 0x1111..0x8888, mem_wren never 1.
- Store with base=0x0020, stride=2, mask=0xA5, lanes=0xA000+i -> writes only to 0x20, 0x24, 0x2A and 0x2E, data 0xA000, 0xA002, 0xA005 and 0xA007; done at cycle +9.
- Load with base=0xFFFE, stride=1 -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0005 (wrap); mask=0x0F gives upper four lanes = 0.
- start re-pulsed during busy and store_vec changed mid-store -> exactly one transfer; RAM holds the original snapshot data.
- reset asserted in ISSUE cycle 3 of a store -> only lanes 0..2 written, no done pulse, all outputs 0 the next cycle, and a new load then completes normally.
- LANES=4, DATA_W=32 -> load latency 6 cycles, correct lane packing.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared parameter defaults and FSM state type for the vector LSU
package vec_pkg;

  localparam int VEC_DATA_W = 16;
  localparam int VEC_LANES  = 8;
  localparam int VEC_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vlsu_state_t;

endpackage

// File: rtl/vlsu_addr_gen.sv
// rtl/vlsu_addr_gen.sv - lane counter and running address accumulator (addr += stride per lane)
module vlsu_addr_gen
  import vec_pkg::*;
#(
  parameter int LANES  = VEC_LANES,
  parameter int ADDR_W = VEC_ADDR_W,
  parameter int LANE_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_i,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [LANE_W-1:0] lane_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Clearing the accumulator after the last lane keeps mem_addr at zero outside ISSUE.
  always_comb begin
    lane_d = lane_q;
    addr_d = addr_q;
    if (clear_i) begin
      lane_d = '0;
      addr_d = '0;
    end else if (init_i) begin
      lane_d = '0;
      addr_d = base_i;
    end else if (step_i) begin
      lane_d = lane_q + LANE_W'(1);
      addr_d = addr_q + stride_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      addr_q <= '0;
    end else begin
      lane_q <= lane_d;
      addr_q <= addr_d;
    end
  end

  assign lane_o = lane_q;
  assign addr_o = addr_q;
  assign last_o = (lane_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - strided vector load/store unit driving a single-port registered RAM
module vector_lsu
  import vec_pkg::*;
#(
  parameter int DATA_W = VEC_DATA_W,
  parameter int LANES  = VEC_LANES,
  parameter int ADDR_W = VEC_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [LANES-1:0]        lane_mask,
  input  logic [LANES*DATA_W-1:0] store_vec,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*DATA_W-1:0] load_vec,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_wren,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int LANE_W = $clog2(LANES);

  vlsu_state_t             state_q;
  logic                    is_store_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    wren_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [ADDR_W-1:0]       stride_q;
  logic [LANES-1:0]        mask_q;
  logic [DATA_W-1:0]       snap_q   [LANES];
  logic [DATA_W-1:0]       shadow_q [LANES];
  logic [LANES*DATA_W-1:0] load_vec_q;

  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] lane_nx;
  logic [LANE_W-1:0] cap_idx;
  logic              last;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata_cap;
  logic              ag_init;
  logic              ag_step;
  logic              ag_clear;

  assign ag_init  = (state_q == IDLE) && start;
  assign ag_step  = (state_q == ISSUE) && !last;
  assign ag_clear = (state_q == ISSUE) && last;

  vlsu_addr_gen #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .init_i   (ag_init),
    .step_i   (ag_step),
    .clear_i  (ag_clear),
    .base_i   (base_addr),
    .stride_i (stride_q),
    .lane_o   (lane),
    .last_o   (last),
    .addr_o   (addr)
  );

  // Read data trails its address by one cycle, so ISSUE lane i captures lane i-1.
  assign lane_nx   = lane + LANE_W'(1);
  assign cap_idx   = (state_q == DRAIN) ? LANE_W'(LANES - 1) : (lane - LANE_W'(1));
  assign rdata_cap = mask_q[cap_idx] ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      stride_q   <= '0;
      mask_q     <= '0;
      load_vec_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        snap_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            is_store_q <= is_store;
            stride_q   <= stride;
            mask_q     <= lane_mask;
            for (int i = 0; i < LANES; i++) snap_q[i] <= store_vec[i*DATA_W +: DATA_W];
            wren_q     <= is_store & lane_mask[0];
            wdata_q    <= is_store ? store_vec[DATA_W-1:0] : '0;
          end
        end
        ISSUE: begin
          if (!is_store_q && (lane != '0)) shadow_q[cap_idx] <= rdata_cap;
          if (last) begin
            wren_q  <= 1'b0;
            wdata_q <= '0;
            if (is_store_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            wren_q  <= is_store_q & mask_q[lane_nx];
            wdata_q <= is_store_q ? snap_q[lane_nx] : '0;
          end
        end
        DRAIN: begin
          shadow_q[LANES-1] <= rdata_cap;
          for (int i = 0; i < LANES - 1; i++) load_vec_q[i*DATA_W +: DATA_W] <= shadow_q[i];
          load_vec_q[(LANES-1)*DATA_W +: DATA_W] <= rdata_cap;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign load_vec  = load_vec_q;
  assign mem_addr  = addr;
  assign mem_wdata = wdata_q;
  assign mem_wren  = wren_q;

endmodule

// File: tb/tb_vector_lsu.sv
// tb/tb_vector_lsu.sv - scoreboard bench for vector_lsu (default config and LANES=4/DATA_W=32)
module tb_vector_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start, is_store;
  logic [15:0]  base_addr, stride;
  logic [7:0]   lane_mask;
  logic [127:0] store_vec, load_vec;
  logic         busy, done, mem_wren;
  logic [15:0]  mem_addr, mem_wdata, mem_rdata;

  logic         start2, is_store2;
  logic [15:0]  base2, stride2;
  logic [3:0]   mask2;
  logic [127:0] store_vec2, load_vec2;
  logic         busy2, done2, mem_wren2;
  logic [15:0]  mem_addr2;
  logic [31:0]  mem_wdata2, mem_rdata2;

  vector_lsu dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .stride(stride), .lane_mask(lane_mask), .store_vec(store_vec),
    .busy(busy), .done(done), .load_vec(load_vec), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  vector_lsu #(.DATA_W(32), .LANES(4), .ADDR_W(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .is_store(is_store2),
    .base_addr(base2), .stride(stride2), .lane_mask(mask2), .store_vec(store_vec2),
    .busy(busy2), .done(done2), .load_vec(load_vec2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_wren(mem_wren2), .mem_rdata(mem_rdata2)
  );

  logic [15:0] ram1 [0:65535];
  logic [31:0] ram2 [0:65535];
  logic        pl1_we, pl2_we;
  logic [15:0] pl1_a, pl1_d, pl2_a;
  logic [31:0] pl2_d;

  always @(posedge clk) begin
    if (pl1_we) ram1[pl1_a] <= pl1_d;
    else if (mem_wren) ram1[mem_addr] <= mem_wdata;
    mem_rdata <= ram1[mem_addr];
  end

  always @(posedge clk) begin
    if (pl2_we) ram2[pl2_a] <= pl2_d;
    else if (mem_wren2) ram2[mem_addr2] <= mem_wdata2;
    mem_rdata2 <= ram2[mem_addr2];
  end

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [127:0] vec; int issue; int lat; } dn_t;

  wr_t         wr_q [$];
  logic [15:0] addr_q [$];
  dn_t         dn_q [$];
  dn_t         dn2_q [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, required none", nm);
  endtask

  // Monitor: pops expectations whenever the DUTs present an address, write or done pulse.
  initial begin
    wr_t e_w;
    dn_t e_d;
    logic [15:0] e_a;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && addr_q.size() > 0) begin
        e_a = addr_q.pop_front();
        check("mem_addr", 128'(mem_addr), 128'(e_a));
      end
      if (mem_wren === 1'b1) begin
        if (wr_q.size() == 0) flag("unexpected_write");
        else begin
          e_w = wr_q.pop_front();
          check("wr_addr", 128'(mem_addr), 128'(e_w.addr));
          check("wr_data", 128'(mem_wdata), 128'(e_w.data));
        end
      end
      if (done === 1'b1) begin
        if (dn_q.size() == 0) flag("unexpected_done");
        else begin
          e_d = dn_q.pop_front();
          check("load_vec", load_vec, e_d.vec);
          check("latency", 128'(cyc - e_d.issue), 128'(e_d.lat));
        end
      end
      if (done2 === 1'b1) begin
        if (dn2_q.size() == 0) flag("unexpected_done2");
        else begin
          e_d = dn2_q.pop_front();
          check("load_vec2", load_vec2, e_d.vec);
          check("latency2", 128'(cyc - e_d.issue), 128'(e_d.lat));
        end
      end
      if (mem_wren2 === 1'b1) flag("unexpected_write2");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pl1(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl1_we = 1'b1; pl1_a = a; pl1_d = d;
    @(posedge clk); #1;
    pl1_we = 1'b0;
  endtask

  task automatic pl2(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pl2_we = 1'b1; pl2_a = a; pl2_d = d;
    @(posedge clk); #1;
    pl2_we = 1'b0;
  endtask

  task automatic go(input logic st, input logic [15:0] b, input logic [15:0] s,
                    input logic [7:0] m, input logic [127:0] v, output int issue);
    @(negedge clk);
    is_store = st; base_addr = b; stride = s; lane_mask = m; store_vec = v; start = 1'b1;
    for (int i = 0; i < 8; i++) addr_q.push_back(b + 16'(i) * s);
    @(posedge clk); #1;
    start = 1'b0;
    issue = cyc;
  endtask

  task automatic go2(input logic [15:0] b, input logic [15:0] s, input logic [3:0] m, output int issue);
    @(negedge clk);
    is_store2 = 1'b0; base2 = b; stride2 = s; mask2 = m; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    issue = cyc;
  endtask

  task automatic wait_done(input bit which);
    bit seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if ((which ? done2 : done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, required one within 30 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, "_busy"},  128'(busy), 128'(0));
    check({nm, "_done"},  128'(done), 128'(0));
    check({nm, "_wren"},  128'(mem_wren), 128'(0));
    check({nm, "_addr"},  128'(mem_addr), 128'(0));
    check({nm, "_wdata"}, 128'(mem_wdata), 128'(0));
    check({nm, "_lvec"},  load_vec, 128'(0));
  endtask

  initial begin
    int iss;
    logic [127:0] v_load1;
    reset = 1'b1;
    start = 1'b0; is_store = 1'b0; base_addr = '0; stride = '0; lane_mask = '0; store_vec = '0;
    start2 = 1'b0; is_store2 = 1'b0; base2 = '0; stride2 = '0; mask2 = '0; store_vec2 = '0;
    pl1_we = 1'b0; pl1_a = '0; pl1_d = '0; pl2_we = 1'b0; pl2_a = '0; pl2_d = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    check("reset_busy2", 128'(busy2), 128'(0));
    check("reset_lvec2", load_vec2, 128'(0));

    // Unit-stride full-mask load
    for (int i = 0; i < 8; i++) pl1(16'h0010 + 16'(i), 16'h1111 * 16'(i + 1));
    v_load1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    go(1'b0, 16'h0010, 16'h0001, 8'hFF, '0, iss);
    dn_q.push_back('{v_load1, iss, 10});
    wait_done(1'b0);

    // Masked stride-2 store; load_vec must keep the previous load result
    wr_q.push_back('{16'h0020, 16'hA000});
    wr_q.push_back('{16'h0024, 16'hA002});
    wr_q.push_back('{16'h002A, 16'hA005});
    wr_q.push_back('{16'h002E, 16'hA007});
    go(1'b1, 16'h0020, 16'h0002, 8'hA5, 128'hA007_A006_A005_A004_A003_A002_A001_A000, iss);
    dn_q.push_back('{v_load1, iss, 9});
    wait_done(1'b0);

    // Address wrap-around with upper lanes masked off
    pl1(16'hFFFE, 16'hC000);
    pl1(16'hFFFF, 16'hC001);
    for (int i = 0; i < 6; i++) pl1(16'(i), 16'hC002 + 16'(i));
    go(1'b0, 16'hFFFE, 16'h0001, 8'h0F, '0, iss);
    dn_q.push_back('{128'h0000_0000_0000_0000_C003_C002_C001_C000, iss, 10});
    wait_done(1'b0);

    // Re-pulsed start while busy (held through DONE) and store data changed mid-transfer
    for (int i = 0; i < 8; i++) wr_q.push_back('{16'h0040 + 16'(i), 16'hB000 + 16'(i)});
    go(1'b1, 16'h0040, 16'h0001, 8'hFF, 128'hB007_B006_B005_B004_B003_B002_B001_B000, iss);
    dn_q.push_back('{128'h0000_0000_0000_0000_C003_C002_C001_C000, iss, 9});
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; base_addr = 16'h0099; store_vec = {8{16'hEEEE}};
    wait_done(1'b0);
    start = 1'b0;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 8; i++) check("ram_snapshot", 128'(ram1[16'h0040 + 16'(i)]), 128'(16'hB000 + 16'(i)));
    check("repulse_queue_empty", 128'(wr_q.size() + dn_q.size()), 128'(0));

    // Reset during ISSUE of a store: lanes 0..2 land, nothing after
    for (int i = 0; i < 8; i++) pl1(16'h0060 + 16'(i), 16'h0000);
    for (int i = 0; i < 3; i++) wr_q.push_back('{16'h0060 + 16'(i), 16'hD000 + 16'(i)});
    go(1'b1, 16'h0060, 16'h0001, 8'hFF, 128'hD007_D006_D005_D004_D003_D002_D001_D000, iss);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    addr_q.delete();
    check("abort_pending_writes", 128'(wr_q.size()), 128'(0));
    wr_q.delete();
    @(negedge clk);
    check_zero_outputs("abort");
    repeat (12) @(negedge clk);
    for (int i = 0; i < 8; i++)
      check("ram_abort", 128'(ram1[16'h0060 + 16'(i)]), (i < 3) ? 128'(16'hD000 + 16'(i)) : 128'(0));
    go(1'b0, 16'h0060, 16'h0001, 8'hFF, '0, iss);
    dn_q.push_back('{128'h0000_0000_0000_0000_0000_D002_D001_D000, iss, 10});
    wait_done(1'b0);

    // Four 32-bit lanes: unit stride full mask, then stride 3 with lanes 1 and 3 masked
    pl2(16'h0100, 32'h0A0B_0C0D);
    pl2(16'h0101, 32'h1122_3344);
    pl2(16'h0102, 32'h5566_7788);
    pl2(16'h0103, 32'h99AA_BBCC);
    go2(16'h0100, 16'h0001, 4'hF, iss);
    dn2_q.push_back('{128'h99AABBCC_55667788_11223344_0A0B0C0D, iss, 6});
    wait_done(1'b1);
    for (int i = 0; i < 4; i++) pl2(16'h0200 + 16'(3 * i), 32'hDEAD_0000 + 32'(i));
    go2(16'h0200, 16'h0003, 4'h5, iss);
    dn2_q.push_back('{128'h00000000_DEAD0002_00000000_DEAD0000, iss, 6});
    wait_done(1'b1);

    repeat (4) @(negedge clk);
    check("final_queues_empty", 128'(dn_q.size() + dn2_q.size() + wr_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
